// File: rtl/fir_sched_pkg.sv
// Shared types and widths for the stereo FIR channel scheduler.
package fir_sched_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned TIMER_W  = 10;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        START_L,
        WAIT_L,
        START_R,
        WAIT_R
    } state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector; a one-cycle
// pulse appears three main_clk edges after the asynchronous input rises.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic edge_q,  edge_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        edge_d  = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            edge_q  <= edge_d;
        end
    end

    assign edge_pulse = edge_q;

endmodule

// File: rtl/fir_chan_sched.sv
// Sequences one shared FIR engine over the L and R channels per audio sample.
// Define FIR_SCHED_STEREO_EN for the L+R sequence; default build is mono.
module fir_chan_sched
    import fir_sched_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  LASTADDR = 7'd100,
    parameter logic [TIMER_W-1:0] TIMEOUT  = 10'd511
) (
    input  logic                main_clk,
    input  logic                reset,
    input  logic                sample_end,
    input  logic [SAMPLE_W-1:0] audio_in_l,
    input  logic [SAMPLE_W-1:0] audio_in_r,
    output logic                rb_write,
    output logic [SAMPLE_W-1:0] rb_data_l,
    output logic [SAMPLE_W-1:0] rb_data_r,
    output logic                fir_start,
    output logic                fir_chan,
    output logic [ADDR_W-1:0]   last_addr,
    input  logic                fir_done,
    input  logic [SAMPLE_W-1:0] fir_result,
    output logic [SAMPLE_W-1:0] audio_out_l,
    output logic [SAMPLE_W-1:0] audio_out_r,
    output logic                busy,
    output logic                overrun
);

    logic edge_pulse;

    state_e              state_q,       state_d;
    logic [TIMER_W-1:0]  timer_q,       timer_d;
    logic                rb_write_q,    rb_write_d;
    logic [SAMPLE_W-1:0] rb_data_l_q,   rb_data_l_d;
    logic [SAMPLE_W-1:0] rb_data_r_q,   rb_data_r_d;
    logic                fir_start_q,   fir_start_d;
    logic                fir_chan_q,    fir_chan_d;
    logic [SAMPLE_W-1:0] audio_out_l_q, audio_out_l_d;
    logic [SAMPLE_W-1:0] audio_out_r_q, audio_out_r_d;
    logic                busy_q,        busy_d;
    logic                overrun_q,     overrun_d;
    state_e              after_l;

    edge_sync u_edge_sync (
        .clk        (main_clk),
        .rst        (reset),
        .async_in   (sample_end),
        .edge_pulse (edge_pulse)
    );

`ifdef FIR_SCHED_STEREO_EN
    assign after_l = START_R;
`else
    assign after_l = IDLE;
`endif

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        rb_data_l_d   = rb_data_l_q;
        rb_data_r_d   = rb_data_r_q;
        audio_out_l_d = audio_out_l_q;
        audio_out_r_d = audio_out_r_q;
        overrun_d     = overrun_q;

        // A sample arriving while a sequence is in flight is lost.
        if (edge_pulse && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (edge_pulse) begin
                    state_d     = WRITE;
                    rb_data_l_d = audio_in_l;
                    rb_data_r_d = audio_in_r;
                end
            end
            WRITE: begin
                state_d = START_L;
            end
            START_L: begin
                timer_d = '0;
                state_d = WAIT_L;
            end
            WAIT_L: begin
                timer_d = timer_q + TIMER_W'(1);
                if (fir_done) begin
                    audio_out_l_d = fir_result;
                    state_d       = after_l;
                end else if (timer_d == TIMEOUT) begin
                    overrun_d = 1'b1;
                    state_d   = after_l;
                end
            end
`ifdef FIR_SCHED_STEREO_EN
            START_R: begin
                timer_d = '0;
                state_d = WAIT_R;
            end
            WAIT_R: begin
                timer_d = timer_q + TIMER_W'(1);
                if (fir_done) begin
                    audio_out_r_d = fir_result;
                    state_d       = IDLE;
                end else if (timer_d == TIMEOUT) begin
                    overrun_d = 1'b1;
                    state_d   = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

`ifndef FIR_SCHED_STEREO_EN
        audio_out_r_d = audio_out_l_d;
`endif

        // Outputs are decoded from the next state so they register in step with it.
        rb_write_d  = (state_d == WRITE);
        fir_start_d = (state_d == START_L) || (state_d == START_R);
`ifdef FIR_SCHED_STEREO_EN
        fir_chan_d  = (state_d == START_R) || (state_d == WAIT_R);
`else
        fir_chan_d  = 1'b0;
`endif
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            rb_write_q    <= 1'b0;
            rb_data_l_q   <= '0;
            rb_data_r_q   <= '0;
            fir_start_q   <= 1'b0;
            fir_chan_q    <= 1'b0;
            audio_out_l_q <= '0;
            audio_out_r_q <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rb_write_q    <= rb_write_d;
            rb_data_l_q   <= rb_data_l_d;
            rb_data_r_q   <= rb_data_r_d;
            fir_start_q   <= fir_start_d;
            fir_chan_q    <= fir_chan_d;
            audio_out_l_q <= audio_out_l_d;
            audio_out_r_q <= audio_out_r_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rb_write    = rb_write_q;
    assign rb_data_l   = rb_data_l_q;
    assign rb_data_r   = rb_data_r_q;
    assign fir_start   = fir_start_q;
    assign fir_chan    = fir_chan_q;
    assign last_addr   = LASTADDR;
    assign audio_out_l = audio_out_l_q;
    assign audio_out_r = audio_out_r_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_fir_chan_sched.sv
// Directed bench for fir_chan_sched with a behavioural FIR engine; adapts
// its expectations to the FIR_SCHED_STEREO_EN build option.
module tb_fir_chan_sched;

`ifdef FIR_SCHED_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    logic        main_clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_end = 1'b0;
    logic [15:0] audio_in_l = '0;
    logic [15:0] audio_in_r = '0;
    logic        rb_write;
    logic [15:0] rb_data_l, rb_data_r;
    logic        fir_start, fir_chan;
    logic [6:0]  last_addr;
    logic        fir_done = 1'b0;
    logic [15:0] fir_result = '0;
    logic [15:0] audio_out_l, audio_out_r;
    logic        busy, overrun;

    fir_chan_sched dut (
        .main_clk    (main_clk),
        .reset       (reset),
        .sample_end  (sample_end),
        .audio_in_l  (audio_in_l),
        .audio_in_r  (audio_in_r),
        .rb_write    (rb_write),
        .rb_data_l   (rb_data_l),
        .rb_data_r   (rb_data_r),
        .fir_start   (fir_start),
        .fir_chan    (fir_chan),
        .last_addr   (last_addr),
        .fir_done    (fir_done),
        .fir_result  (fir_result),
        .audio_out_l (audio_out_l),
        .audio_out_r (audio_out_r),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 main_clk = ~main_clk;

    int tests = 0;
    int fails = 0;

    // Engine model controls (written by the test) and observed counters.
    bit          eng_en = 1'b1;
    int          eng_lat = 10;
    logic [15:0] res_l = '0, res_r = '0;
    bit          clr_tog = 1'b0, clr_seen = 1'b0;
    bit          stray_tog = 1'b0, stray_seen = 1'b0;
    int          eng_cnt = 0;
    bit          eng_ch = 1'b0;
    int          rbw_cnt = 0, start_cnt = 0, chan1_start_cnt = 0, chan_hi_cycles = 0;

    always @(negedge main_clk) begin
        fir_done = 1'b0;
        if (clr_tog != clr_seen) begin
            clr_seen = clr_tog;
            rbw_cnt = 0; start_cnt = 0; chan1_start_cnt = 0; chan_hi_cycles = 0;
        end
        if (stray_tog != stray_seen) begin
            stray_seen = stray_tog;
            fir_done   = 1'b1;
            fir_result = 16'h5555;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                fir_done   = 1'b1;
                fir_result = eng_ch ? res_r : res_l;
            end
        end
        if (rb_write) rbw_cnt++;
        if (fir_chan) chan_hi_cycles++;
        if (fir_start) begin
            start_cnt++;
            if (fir_chan) chan1_start_cnt++;
            if (eng_en) begin
                eng_ch  = fir_chan;
                eng_cnt = eng_lat;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_sample(input logic [15:0] l, input logic [15:0] r);
        @(negedge main_clk);
        audio_in_l = l;
        audio_in_r = r;
        sample_end = 1'b1;
        repeat (4) @(negedge main_clk);
        sample_end = 1'b0;
    endtask

    task automatic run_to_idle(output bit ok, output int len);
        int n;
        ok = 1'b0;
        len = 0;
        n = 0;
        while (!busy && n < 20) begin @(negedge main_clk); n++; end
        if (!busy) return;
        while (busy && len < 3000) begin @(negedge main_clk); len++; end
        ok = !busy;
    endtask

    task automatic clear_counts();
        clr_tog = ~clr_tog;
        @(negedge main_clk);
        @(negedge main_clk);
    endtask

    task automatic pulse_reset();
        @(negedge main_clk);
        reset = 1'b1;
        @(negedge main_clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [15:0] l_in, r_in, res_l, res_r;
        int          lat;
        logic [15:0] exp_l, exp_r_st, exp_r_mono;
    } vec_t;

    vec_t vecs[4];

    initial begin
        bit ok;
        int len;
        int n;
        logic [15:0] exp_r;

        vecs[0] = '{16'h1234, 16'hABCD, 16'h0100, 16'h0200, 110, 16'h0100, 16'h0200, 16'h0100};
        vecs[1] = '{16'h8000, 16'h0001, 16'hFFFF, 16'h8000, 1,   16'hFFFF, 16'h8000, 16'hFFFF};
        vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h1111, 5,   16'h7FFF, 16'h1111, 16'h7FFF};
        vecs[3] = '{16'h0000, 16'hFFFF, 16'h0042, 16'h0000, 30,  16'h0042, 16'h0000, 16'h0042};

        repeat (3) @(negedge main_clk);
        reset = 1'b0;
        @(negedge main_clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_rb_write", 32'(rb_write), 32'h0);
        check("rst_fir_start", 32'(fir_start), 32'h0);
        check("rst_fir_chan", 32'(fir_chan), 32'h0);
        check("rst_audio_out_l", 32'(audio_out_l), 32'h0);
        check("rst_audio_out_r", 32'(audio_out_r), 32'h0);
        check("rst_rb_data_l", 32'(rb_data_l), 32'h0);
        check("last_addr", 32'(last_addr), 32'd100);

        // Stray fir_done while idle
        stray_tog = ~stray_tog;
        repeat (4) @(negedge main_clk);
        check("stray_busy", 32'(busy), 32'h0);
        check("stray_out_l", 32'(audio_out_l), 32'h0);
        check("stray_out_r", 32'(audio_out_r), 32'h0);
        check("stray_overrun", 32'(overrun), 32'h0);

        // Table-driven basic sequences
        for (int i = 0; i < 4; i++) begin
            eng_en  = 1'b1;
            eng_lat = vecs[i].lat;
            res_l   = vecs[i].res_l;
            res_r   = vecs[i].res_r;
            clear_counts();
            send_sample(vecs[i].l_in, vecs[i].r_in);
            run_to_idle(ok, len);
            repeat (2) @(negedge main_clk);
            exp_r = STEREO ? vecs[i].exp_r_st : vecs[i].exp_r_mono;
            check($sformatf("v%0d_done", i), 32'(ok), 32'h1);
            check($sformatf("v%0d_out_l", i), 32'(audio_out_l), 32'(vecs[i].exp_l));
            check($sformatf("v%0d_out_r", i), 32'(audio_out_r), 32'(exp_r));
            check($sformatf("v%0d_rb_data_l", i), 32'(rb_data_l), 32'(vecs[i].l_in));
            check($sformatf("v%0d_rb_data_r", i), 32'(rb_data_r), 32'(vecs[i].r_in));
            check($sformatf("v%0d_rb_writes", i), 32'(rbw_cnt), 32'd1);
            check($sformatf("v%0d_starts", i), 32'(start_cnt), STEREO ? 32'd2 : 32'd1);
            check($sformatf("v%0d_chan1_starts", i), 32'(chan1_start_cnt), STEREO ? 32'd1 : 32'd0);
            if (!STEREO) check($sformatf("v%0d_chan_hi", i), 32'(chan_hi_cycles), 32'd0);
            check($sformatf("v%0d_overrun", i), 32'(overrun), 32'h0);
        end

        // Second sample during WAIT_L is dropped and flagged
        eng_lat = 110;
        res_l = 16'h0AAA;
        res_r = 16'h0BBB;
        clear_counts();
        send_sample(16'h0001, 16'h0002);
        repeat (20) @(negedge main_clk);
        send_sample(16'h5A5A, 16'hA5A5);
        run_to_idle(ok, len);
        repeat (2) @(negedge main_clk);
        check("ovr_done", 32'(ok), 32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_rb_writes", 32'(rbw_cnt), 32'd1);
        check("ovr_rb_data_l", 32'(rb_data_l), 32'h0001);
        check("ovr_out_l", 32'(audio_out_l), 32'h0AAA);
        check("ovr_out_r", 32'(audio_out_r), STEREO ? 32'h0BBB : 32'h0AAA);
        repeat (20) @(negedge main_clk);
        check("ovr_sticky", 32'(overrun), 32'h1);
        check("ovr_no_restart", 32'(busy), 32'h0);

        // Engine timeout: outputs hold, overrun sets, sequence still finishes
        pulse_reset();
        eng_lat = 8;
        res_l = 16'h1357;
        res_r = 16'h2468;
        send_sample(16'h1111, 16'h2222);
        run_to_idle(ok, len);
        repeat (2) @(negedge main_clk);
        check("to_pre_overrun", 32'(overrun), 32'h0);
        eng_en = 1'b0;
        clear_counts();
        send_sample(16'h3333, 16'h4444);
        run_to_idle(ok, len);
        repeat (2) @(negedge main_clk);
        check("to_done", 32'(ok), 32'h1);
        check("to_busy_len", 32'(len), STEREO ? 32'd1025 : 32'd513);
        check("to_overrun", 32'(overrun), 32'h1);
        check("to_out_l", 32'(audio_out_l), 32'h1357);
        check("to_out_r", 32'(audio_out_r), STEREO ? 32'h2468 : 32'h1357);
        check("to_starts", 32'(start_cnt), STEREO ? 32'd2 : 32'd1);
        eng_en = 1'b1;

        // Reset in the middle of the final wait state
        pulse_reset();
        eng_lat = 150;
        res_l = 16'h0C0C;
        res_r = 16'h0D0D;
        send_sample(16'h0101, 16'h0202);
        n = 0;
        if (STEREO) begin
            while (!fir_chan && n < 400) begin @(negedge main_clk); n++; end
            check("mid_reached_wait_r", 32'(fir_chan), 32'h1);
        end
        repeat (10) @(negedge main_clk);
        check("mid_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge main_clk);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_chan", 32'(fir_chan), 32'h0);
        check("mid_start", 32'(fir_start), 32'h0);
        check("mid_out_l", 32'(audio_out_l), 32'h0);
        check("mid_out_r", 32'(audio_out_r), 32'h0);
        check("mid_rb_data_r", 32'(rb_data_r), 32'h0);
        reset = 1'b0;
        // Leftover engine completion lands while idle and must be ignored
        repeat (200) @(negedge main_clk);
        check("mid_late_done_out_l", 32'(audio_out_l), 32'h0);
        check("mid_late_done_busy", 32'(busy), 32'h0);
        eng_lat = 20;
        res_l = 16'h0F0F;
        res_r = 16'hF0F0;
        clear_counts();
        send_sample(16'h0303, 16'h0404);
        run_to_idle(ok, len);
        repeat (2) @(negedge main_clk);
        check("post_done", 32'(ok), 32'h1);
        check("post_out_l", 32'(audio_out_l), 32'h0F0F);
        check("post_out_r", 32'(audio_out_r), STEREO ? 32'hF0F0 : 32'h0F0F);
        check("post_starts", 32'(start_cnt), STEREO ? 32'd2 : 32'd1);
        check("post_overrun", 32'(overrun), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
